// File: rtl/simd_fu_pipe.sv
// Pipelined packed-SIMD functional unit: fixed MUL_LAT latency, valid/ready
// handshake with full-pipe stall, tag tracking and a multi-beat VREDSUM accumulator.
module simd_fu_pipe #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned ID_W    = 4,
  parameter int unsigned TAG_W   = 6
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [ID_W-1:0]   fu_id_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [3:0]        in_op_i,
  input  logic [1:0]        in_sew_i,
  input  logic [TAG_W-1:0]  in_tag_i,
  input  logic              in_last_i,
  input  logic [DATA_W-1:0] data_vs1_i,
  input  logic [DATA_W-1:0] data_vs2_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [TAG_W-1:0]  out_tag_o,
  output logic [DATA_W-1:0] data_vd_o,
  output logic              busy_o
);

  localparam int unsigned E8  = DATA_W / 8;
  localparam int unsigned E16 = DATA_W / 16;
  localparam int unsigned E32 = DATA_W / 32;
  localparam int unsigned E64 = DATA_W / 64;

  localparam logic [3:0] OP_VADD = 4'd0,  OP_VSUB  = 4'd1,  OP_VMIN  = 4'd2,  OP_VMINU = 4'd3;
  localparam logic [3:0] OP_VMAX = 4'd4,  OP_VMAXU = 4'd5,  OP_VAND  = 4'd6,  OP_VOR   = 4'd7;
  localparam logic [3:0] OP_VXOR = 4'd8,  OP_VSLL  = 4'd9,  OP_VSRL  = 4'd10, OP_VSRA  = 4'd11;
  localparam logic [3:0] OP_VMUL = 4'd12, OP_VID   = 4'd13, OP_VRED  = 4'd14;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  function automatic logic [63:0] sext(input logic [63:0] x, input logic [1:0] sew);
    case (sew)
      2'd0:    sext = {{56{x[7]}}, x[7:0]};
      2'd1:    sext = {{48{x[15]}}, x[15:0]};
      2'd2:    sext = {{32{x[31]}}, x[31:0]};
      default: sext = x;
    endcase
  endfunction

  // One element op on zero-extended operands; caller truncates to SEW.
  function automatic logic [63:0] elem_op(input logic [3:0] op, input logic [1:0] sew,
                                          input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] vid);
    logic [63:0] sa, sb;
    logic [5:0]  sh;
    sa = sext(a, sew);
    sb = sext(b, sew);
    case (sew)
      2'd0:    sh = {3'd0, b[2:0]};
      2'd1:    sh = {2'd0, b[3:0]};
      2'd2:    sh = {1'b0, b[4:0]};
      default: sh = b[5:0];
    endcase
    case (op)
      OP_VADD:  elem_op = a + b;
      OP_VSUB:  elem_op = a - b;
      OP_VMIN:  elem_op = ($signed(sa) < $signed(sb)) ? a : b;
      OP_VMINU: elem_op = (a < b) ? a : b;
      OP_VMAX:  elem_op = ($signed(sa) > $signed(sb)) ? a : b;
      OP_VMAXU: elem_op = (a > b) ? a : b;
      OP_VAND:  elem_op = a & b;
      OP_VOR:   elem_op = a | b;
      OP_VXOR:  elem_op = a ^ b;
      OP_VSLL:  elem_op = a << sh;
      OP_VSRL:  elem_op = a >> sh;
      OP_VSRA:  elem_op = $signed(sa) >>> sh;
      OP_VMUL:  elem_op = a * b;
      OP_VID:   elem_op = vid;
      default:  elem_op = a;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] ew_add(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic [1:0] sew);
    logic [DATA_W-1:0] r;
    r = '0;
    case (sew)
      2'd0:    for (int i = 0; i < int'(E8);  i++) r[i*8  +: 8]  = a[i*8  +: 8]  + b[i*8  +: 8];
      2'd1:    for (int i = 0; i < int'(E16); i++) r[i*16 +: 16] = a[i*16 +: 16] + b[i*16 +: 16];
      2'd2:    for (int i = 0; i < int'(E32); i++) r[i*32 +: 32] = a[i*32 +: 32] + b[i*32 +: 32];
      default: for (int i = 0; i < int'(E64); i++) r[i*64 +: 64] = a[i*64 +: 64] + b[i*64 +: 64];
    endcase
    return r;
  endfunction

  // Horizontal sum of all elements into element 0, wrapped to SEW.
  function automatic logic [DATA_W-1:0] hsum(input logic [DATA_W-1:0] s, input logic [1:0] sew);
    logic [63:0] t;
    t = '0;
    case (sew)
      2'd0:    for (int i = 0; i < int'(E8);  i++) t[7:0]  = t[7:0]  + s[i*8  +: 8];
      2'd1:    for (int i = 0; i < int'(E16); i++) t[15:0] = t[15:0] + s[i*16 +: 16];
      2'd2:    for (int i = 0; i < int'(E32); i++) t[31:0] = t[31:0] + s[i*32 +: 32];
      default: for (int i = 0; i < int'(E64); i++) t       = t       + s[i*64 +: 64];
    endcase
    return DATA_W'(t);
  endfunction

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [1:0]        acc_sew_q, acc_sew_d;

  logic [MUL_LAT-1:0] stg_vld;
  logic [TAG_W-1:0]   stg_tag  [MUL_LAT];
  logic [DATA_W-1:0]  stg_data [MUL_LAT];

  logic              adv, accept, is_red, produce;
  logic [1:0]        eff_sew;
  logic [63:0]       id64;
  logic [DATA_W-1:0] r8, r16, r32, r64, alu_res, red_sum, red_res, res_in;

  assign adv        = !out_valid_o || out_ready_i;
  assign in_ready_o = adv && !flush_i;
  assign accept     = in_valid_i && in_ready_o;
  assign is_red     = (in_op_i == OP_VRED);
  assign produce    = accept && !(is_red && !in_last_i);
  assign id64       = 64'(fu_id_i);

  // Element-wise ALU evaluated at every SEW, then selected.
  always_comb begin
    r8  = '0;
    r16 = '0;
    r32 = '0;
    r64 = '0;
    for (int i = 0; i < int'(E8); i++)
      r8[i*8 +: 8] = 8'(elem_op(in_op_i, 2'd0, 64'(data_vs1_i[i*8 +: 8]),
                                64'(data_vs2_i[i*8 +: 8]), id64 * 64'(E8) + 64'(i)));
    for (int i = 0; i < int'(E16); i++)
      r16[i*16 +: 16] = 16'(elem_op(in_op_i, 2'd1, 64'(data_vs1_i[i*16 +: 16]),
                                    64'(data_vs2_i[i*16 +: 16]), id64 * 64'(E16) + 64'(i)));
    for (int i = 0; i < int'(E32); i++)
      r32[i*32 +: 32] = 32'(elem_op(in_op_i, 2'd2, 64'(data_vs1_i[i*32 +: 32]),
                                    64'(data_vs2_i[i*32 +: 32]), id64 * 64'(E32) + 64'(i)));
    for (int i = 0; i < int'(E64); i++)
      r64[i*64 +: 64] = elem_op(in_op_i, 2'd3, data_vs1_i[i*64 +: 64],
                                data_vs2_i[i*64 +: 64], id64 * 64'(E64) + 64'(i));
    case (in_sew_i)
      2'd0:    alu_res = r8;
      2'd1:    alu_res = r16;
      2'd2:    alu_res = r32;
      default: alu_res = r64;
    endcase
  end

  // Reduction datapath; an open reduction keeps its element width.
  assign eff_sew = (state_q == ST_ACCUM) ? acc_sew_q : in_sew_i;
  assign red_sum = ew_add(ew_add((state_q == ST_ACCUM) ? acc_q : '0, data_vs1_i, eff_sew),
                          data_vs2_i, eff_sew);
  assign red_res = hsum(red_sum, eff_sew);
  assign res_in  = is_red ? red_res : alu_res;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    acc_sew_d = acc_sew_q;
    if (flush_i) begin
      state_d   = ST_IDLE;
      acc_d     = '0;
      acc_sew_d = 2'd0;
    end else if (accept && is_red) begin
      if (in_last_i) begin
        state_d = ST_IDLE;
        acc_d   = '0;
      end else begin
        state_d   = ST_ACCUM;
        acc_d     = red_sum;
        acc_sew_d = eff_sew;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      acc_sew_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      acc_sew_q <= acc_sew_d;
    end
  end

  // Lock-step shift pipeline; the last stage is the output register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      stg_vld <= '0;
      for (int i = 0; i < int'(MUL_LAT); i++) begin
        stg_tag[i]  <= '0;
        stg_data[i] <= '0;
      end
    end else if (flush_i) begin
      stg_vld <= '0;
    end else if (adv) begin
      stg_vld[0]  <= produce;
      stg_tag[0]  <= in_tag_i;
      stg_data[0] <= res_in;
      for (int i = 1; i < int'(MUL_LAT); i++) begin
        stg_vld[i]  <= stg_vld[i-1];
        stg_tag[i]  <= stg_tag[i-1];
        stg_data[i] <= stg_data[i-1];
      end
    end
  end

  assign out_valid_o = stg_vld[MUL_LAT-1];
  assign out_tag_o   = stg_tag[MUL_LAT-1];
  assign data_vd_o   = stg_data[MUL_LAT-1];
  assign busy_o      = (|stg_vld) || (state_q == ST_ACCUM);

endmodule
